// File: rtl/cell_rd_wr_sequencer_pkg.sv
// Shared constants and the RAM-port operation type for the cell position RAM sequencer.
package cell_rd_wr_sequencer_pkg;

  localparam int CELL_COUNT_ADDR     = 0;
  localparam int CELL_MEM_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    MEM_NOP = 2'd0,
    MEM_RD  = 2'd1,
    MEM_WR  = 2'd2
  } mem_op_e;

endpackage

// File: rtl/cell_rd_wr_sequencer_if.sv
// Bus bundle between the cell sequencer, its read/write clients and the single-port position RAM.
interface cell_rd_wr_sequencer_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  rd_start;
  logic                  rd_busy;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] particle_count;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pid;
  logic [DATA_WIDTH-1:0] out_pos;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport master (
    input  rd_start, wr_req, wr_addr, wr_data, mem_q,
    output rd_busy, rd_done, particle_count, out_valid, out_pid, out_pos,
           wr_ack, mem_address, mem_data, mem_rden, mem_wren
  );

  modport slave (
    output rd_start, wr_req, wr_addr, wr_data, mem_q,
    input  rd_busy, rd_done, particle_count, out_valid, out_pid, out_pos,
           wr_ack, mem_address, mem_data, mem_rden, mem_wren
  );

endinterface

// File: rtl/cell_rd_tag_pipe.sv
// {valid,pid} shift register that tracks reads in flight through the RAM's fixed read latency.
module cell_rd_tag_pipe
  import cell_rd_wr_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = CELL_MEM_RD_LATENCY
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  i_push_vld,
  input  logic [ADDR_WIDTH-1:0] i_push_pid,
  output logic                  o_vld,
  output logic [ADDR_WIDTH-1:0] o_pid
);

  logic                  r_vld [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pid [DEPTH];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_pid[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_push_vld;
      r_pid[0] <= i_push_vld ? i_push_pid : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_pid = r_pid[DEPTH-1];

endmodule

// File: rtl/cell_rd_wr_sequencer.sv
// Sole controller of one cell position RAM: streams a cell on rd_start, arbitrates writes.
// Optional macro CELL_SEQ_PERF_CNT_EN adds perf_cells_read / perf_wr_stall counters.
module cell_rd_wr_sequencer
  import cell_rd_wr_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    rst,
  cell_rd_wr_sequencer_if.master  bus
`ifdef CELL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cells_read,
  output logic [31:0]             perf_wr_stall
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE    = 3'd1;
  localparam logic [2:0] S_RD_CNT   = 3'd2;
  localparam logic [2:0] S_CNT_WAIT = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] MAX_PID  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(CELL_COUNT_ADDR);

  function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_PID) ? MAX_PID : raw;
  endfunction

  logic [2:0]            r_state;
  logic                  r_cnt_wait;
  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_rden;
  logic                  r_mem_wren;

  logic [2:0]            w_next_state;
  mem_op_e               w_op;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [ADDR_WIDTH-1:0] w_count;
  logic                  w_push_vld;
  logic                  w_tag_vld;
  logic [ADDR_WIDTH-1:0] w_tag_pid;
  logic                  w_rd_done;

  assign w_count    = clamp_count(bus.mem_q[ADDR_WIDTH-1:0]);
  assign w_push_vld = (r_state == S_STREAM);

  // A zero-length cell finishes on its first DRAIN cycle; otherwise on the return of pid N.
  assign w_rd_done = (r_state == S_DRAIN) &&
                     ((r_count == '0) || (w_tag_vld && (w_tag_pid == r_count)));

  cell_rd_tag_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_tag_pipe (
    .clock      (clock),
    .rst        (rst),
    .i_push_vld (w_push_vld),
    .i_push_pid (r_mem_address),
    .o_vld      (w_tag_vld),
    .o_pid      (w_tag_pid)
  );

  // State register, plus registered RAM port and count latch.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt_wait    <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_count       <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_rden    <= 1'b0;
      r_mem_wren    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt_wait <= (r_state == S_CNT_WAIT) && !r_cnt_wait;
      if ((r_state == S_IDLE) && bus.rd_start && bus.wr_req)
        r_rd_pend <= 1'b1;
      else if (w_next_state == S_RD_CNT)
        r_rd_pend <= 1'b0;
      if ((r_state == S_CNT_WAIT) && r_cnt_wait)
        r_count <= w_count;
      r_mem_rden    <= (w_op == MEM_RD);
      r_mem_wren    <= (w_op == MEM_WR);
      r_mem_address <= w_addr;
      r_mem_data    <= w_data;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_req)
          w_next_state = S_WRITE;
        else if (bus.rd_start || r_rd_pend)
          w_next_state = S_RD_CNT;
      end
      S_WRITE:    w_next_state = S_IDLE;
      S_RD_CNT:   w_next_state = S_CNT_WAIT;
      S_CNT_WAIT: begin
        if (r_cnt_wait)
          w_next_state = (w_count == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (r_mem_address >= r_count)
          w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_rd_done)
          w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output logic: the RAM command for the coming cycle follows the state being entered.
  always_comb begin
    w_op   = MEM_NOP;
    w_addr = '0;
    w_data = '0;
    case (w_next_state)
      S_WRITE: begin
        w_op   = MEM_WR;
        w_addr = bus.wr_addr;
        w_data = bus.wr_data;
      end
      S_RD_CNT: begin
        w_op   = MEM_RD;
        w_addr = CNT_ADDR;
      end
      S_STREAM: begin
        w_op   = MEM_RD;
        w_addr = (r_state == S_STREAM) ? r_mem_address + ADDR_WIDTH'(1) : ADDR_WIDTH'(1);
      end
      default: begin
        w_op   = MEM_NOP;
        w_addr = '0;
        w_data = '0;
      end
    endcase
  end

  assign bus.rd_busy        = (r_state != S_IDLE) && (r_state != S_WRITE);
  assign bus.rd_done        = w_rd_done;
  assign bus.wr_ack         = (r_state == S_WRITE);
  assign bus.particle_count = r_count;
  assign bus.out_valid      = w_tag_vld;
  assign bus.out_pid        = w_tag_pid;
  assign bus.out_pos        = w_tag_vld ? bus.mem_q : '0;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_data       = r_mem_data;
  assign bus.mem_rden       = r_mem_rden;
  assign bus.mem_wren       = r_mem_wren;

`ifdef CELL_SEQ_PERF_CNT_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      perf_cells_read <= '0;
      perf_wr_stall   <= '0;
    end else begin
      if (w_rd_done)
        perf_cells_read <= perf_cells_read + 32'd1;
      if (bus.wr_req && !bus.wr_ack)
        perf_wr_stall <= perf_wr_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_rd_wr_sequencer.sv
// Directed bench for cell_rd_wr_sequencer with a 2-cycle-latency single-port RAM model.
module tb_cell_rd_wr_sequencer;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  cell_rd_wr_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef CELL_SEQ_PERF_CNT_EN
  logic [31:0] perf_cells_read;
  logic [31:0] perf_wr_stall;
`endif

  cell_rd_wr_sequencer #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
`ifdef CELL_SEQ_PERF_CNT_EN
    ,
    .perf_cells_read (perf_cells_read),
    .perf_wr_stall   (perf_wr_stall)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int k);
    return {32'(k * 7 + 1000), 32'(k * 3 + 5), 32'(32'hC0DE0000 + k)};
  endfunction

  // RAM model: read data appears two cycles after the mem_* command cycle.
  logic [DW-1:0] ram [0:PN-1];
  logic [DW-1:0] ram_s1 = '0;
  logic          ld_req = 1'b0;
  logic [7:0]    ld_cnt = 8'd0;

  always @(posedge clock) begin
    if (ld_req) begin
      for (int k = 1; k < PN; k++) ram[k] <= init_word(k);
      ram[0] <= {88'hABCDEF, ld_cnt};
    end else if (bus.mem_wren) begin
      ram[bus.mem_address] <= bus.mem_data;
    end
    if (bus.mem_rden) ram_s1 <= ram[bus.mem_address];
    bus.mem_q <= ram_s1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_ram(input logic [7:0] cnt);
    ld_cnt = cnt;
    ld_req = 1'b1;
    step();
    ld_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clock);
    n_assert++;
    if ({bus.rd_busy, bus.rd_done, bus.out_valid, bus.wr_ack, bus.mem_rden, bus.mem_wren} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.rd_busy, bus.rd_done, bus.out_valid, bus.wr_ack, bus.mem_rden, bus.mem_wren});
    end
    n_assert++;
    if ({bus.out_pid, bus.particle_count, bus.mem_address} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h required 000000", {bus.out_pid, bus.particle_count, bus.mem_address});
    end
    n_assert++;
    if (bus.out_pos !== '0 || bus.mem_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got pos %h data %h required 0", bus.out_pos, bus.mem_data);
    end
    step();
    rst = 1'b0;
    repeat (2) step();
    @(negedge clock);
    n_assert++;
    if (bus.rd_busy !== 1'b0 || bus.mem_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy %b rden %b required 0 0", bus.rd_busy, bus.mem_rden);
    end
  endtask

  task automatic test_count5();
    logic exp_v;
    load_ram(8'd5);
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      bus.rd_start = 1'b0;
      @(negedge clock);
      exp_v = (c >= 6 && c <= 10);
      n_assert++;
      if (bus.out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL t1_valid c=%0d: got %b required %b", c, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        n_assert++;
        if (bus.out_pid !== 8'(c - 5) || bus.out_pos !== init_word(c - 5)) begin
          n_fail++;
          $display("FAIL t1_beat c=%0d: got pid %0d pos %h required pid %0d pos %h",
                   c, bus.out_pid, bus.out_pos, c - 5, init_word(c - 5));
        end
      end
      n_assert++;
      if (bus.rd_done !== (c == 10) || bus.rd_busy !== (c <= 10)) begin
        n_fail++;
        $display("FAIL t1_done_busy c=%0d: got done %b busy %b required %b %b",
                 c, bus.rd_done, bus.rd_busy, (c == 10), (c <= 10));
      end
    end
    n_assert++;
    if (bus.particle_count !== 8'd5) begin
      n_fail++;
      $display("FAIL t1_count: got %0d required 5", bus.particle_count);
    end
  endtask

  task automatic test_count0();
    load_ram(8'd0);
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.rd_start = 1'b0;
      @(negedge clock);
      n_assert++;
      if (bus.out_valid !== 1'b0 || bus.rd_done !== (c == 4) || bus.rd_busy !== (c <= 4)) begin
        n_fail++;
        $display("FAIL t2_zero c=%0d: got valid %b done %b busy %b required 0 %b %b",
                 c, bus.out_valid, bus.rd_done, bus.rd_busy, (c == 4), (c <= 4));
      end
    end
    n_assert++;
    if (bus.particle_count !== 8'd0) begin
      n_fail++;
      $display("FAIL t2_count: got %0d required 0", bus.particle_count);
    end
  endtask

  task automatic test_clamp();
    int beats = 0;
    int errs = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    logic [7:0] last_pid = 8'd0;
    load_ram(8'd250);
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 232; c++) begin
      step();
      bus.rd_start = 1'b0;
      @(negedge clock);
      if (bus.out_valid === 1'b1) begin
        beats++;
        last_pid = bus.out_pid;
        if (bus.out_pid !== 8'(beats) || bus.out_pos !== init_word(beats) || c != beats + 5) errs++;
      end
      if (bus.rd_done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    n_assert++;
    if (beats != 219) begin n_fail++; $display("FAIL t3_beats: got %0d required 219", beats); end
    n_assert++;
    if (errs != 0) begin n_fail++; $display("FAIL t3_beat_content: got %0d bad beats required 0", errs); end
    n_assert++;
    if (last_pid !== 8'd219) begin n_fail++; $display("FAIL t3_last_pid: got %0d required 219", last_pid); end
    n_assert++;
    if (bus.particle_count !== 8'd219) begin
      n_fail++;
      $display("FAIL t3_count: got %0d required 219", bus.particle_count);
    end
    n_assert++;
    if (done_cyc != 224 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL t3_done: got cycle %0d pulses %0d required 224 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_rd_wr_same();
    logic          exp_v;
    logic [DW-1:0] xw;
    logic [DW-1:0] exp_pos;
    xw = 96'hDEADBEEF_0BADF00D_12345678;
    load_ram(8'd5);
    bus.rd_start = 1'b1;
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 8'd3;
    bus.wr_data  = xw;
    for (int c = 1; c <= 15; c++) begin
      step();
      bus.rd_start = 1'b0;
      if (c == 2) begin
        bus.wr_req  = 1'b0;
        bus.wr_addr = 8'd0;
        bus.wr_data = '0;
      end
      @(negedge clock);
      n_assert++;
      if (bus.wr_ack !== (c == 1)) begin
        n_fail++;
        $display("FAIL t4_ack c=%0d: got %b required %b", c, bus.wr_ack, (c == 1));
      end
      if (c == 1) begin
        n_assert++;
        if (bus.mem_wren !== 1'b1 || bus.mem_rden !== 1'b0 || bus.mem_address !== 8'd3 || bus.mem_data !== xw) begin
          n_fail++;
          $display("FAIL t4_wr_cmd: got wren %b rden %b addr %0d data %h required 1 0 3 %h",
                   bus.mem_wren, bus.mem_rden, bus.mem_address, bus.mem_data, xw);
        end
      end
      exp_v   = (c >= 8 && c <= 12);
      exp_pos = (c == 10) ? xw : init_word(c - 7);
      n_assert++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_pid !== 8'(c - 7) || bus.out_pos !== exp_pos))) begin
        n_fail++;
        $display("FAIL t4_beat c=%0d: got valid %b pid %0d pos %h required %b %0d %h",
                 c, bus.out_valid, bus.out_pid, bus.out_pos, exp_v, c - 7, exp_pos);
      end
      n_assert++;
      if (bus.rd_done !== (c == 12)) begin
        n_fail++;
        $display("FAIL t4_done c=%0d: got %b required %b", c, bus.rd_done, (c == 12));
      end
    end
  endtask

  task automatic test_wr_during_read();
    logic          exp_v;
    logic [DW-1:0] yw;
    yw = 96'h11112222_33334444_55556666;
    load_ram(8'd5);
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      bus.rd_start = 1'b0;
      if (c == 5) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = 8'd7;
        bus.wr_data = yw;
      end
      if (c == 13) begin
        bus.wr_req  = 1'b0;
        bus.wr_addr = 8'd0;
        bus.wr_data = '0;
      end
      @(negedge clock);
      exp_v = (c >= 6 && c <= 10);
      n_assert++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_pid !== 8'(c - 5) || bus.out_pos !== init_word(c - 5)))) begin
        n_fail++;
        $display("FAIL t5_beat c=%0d: got valid %b pid %0d pos %h required %b %0d %h",
                 c, bus.out_valid, bus.out_pid, bus.out_pos, exp_v, c - 5, init_word(c - 5));
      end
      n_assert++;
      if (bus.wr_ack !== (c == 12) || bus.rd_done !== (c == 10)) begin
        n_fail++;
        $display("FAIL t5_ack_done c=%0d: got ack %b done %b required %b %b",
                 c, bus.wr_ack, bus.rd_done, (c == 12), (c == 10));
      end
      n_assert++;
      if ((bus.mem_rden & bus.mem_wren) !== 1'b0) begin
        n_fail++;
        $display("FAIL t5_port_overlap c=%0d: got rden %b wren %b required not both", c, bus.mem_rden, bus.mem_wren);
      end
    end
    n_assert++;
    if (ram[7] !== yw) begin
      n_fail++;
      $display("FAIL t5_ram_write: got %h required %h", ram[7], yw);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic exp_v;
    load_ram(8'd5);
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.rd_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clock);
    n_assert++;
    if ({bus.rd_busy, bus.rd_done, bus.out_valid, bus.wr_ack, bus.mem_rden, bus.mem_wren,
         bus.out_pid, bus.particle_count, bus.mem_address} !== 30'h0 || bus.out_pos !== '0) begin
      n_fail++;
      $display("FAIL t6_reset_outputs: got busy %b done %b valid %b pid %0d count %0d rden %b pos %h required all 0",
               bus.rd_busy, bus.rd_done, bus.out_valid, bus.out_pid, bus.particle_count, bus.mem_rden, bus.out_pos);
    end
    step();
    rst = 1'b0;
    for (int c = 9; c <= 14; c++) begin
      @(negedge clock);
      n_assert++;
      if (bus.out_valid !== 1'b0 || bus.rd_done !== 1'b0 || bus.rd_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_quiet c=%0d: got valid %b done %b busy %b required 0 0 0",
                 c, bus.out_valid, bus.rd_done, bus.rd_busy);
      end
      step();
    end
    bus.rd_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.rd_start = 1'b0;
      @(negedge clock);
      exp_v = (c >= 6 && c <= 10);
      n_assert++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_pid !== 8'(c - 5) || bus.out_pos !== init_word(c - 5)))) begin
        n_fail++;
        $display("FAIL t6_fresh_beat c=%0d: got valid %b pid %0d pos %h required %b %0d %h",
                 c, bus.out_valid, bus.out_pid, bus.out_pos, exp_v, c - 5, init_word(c - 5));
      end
      n_assert++;
      if (bus.rd_done !== (c == 10)) begin
        n_fail++;
        $display("FAIL t6_fresh_done c=%0d: got %b required %b", c, bus.rd_done, (c == 10));
      end
    end
  endtask

  initial begin
    bus.rd_start = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    test_reset();
    test_count5();
    step();
    test_count0();
    step();
    test_clamp();
    step();
    test_rd_wr_same();
    step();
    test_wr_during_read();
    step();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
